rv32e_ex_stage: RTL
===================

// Module: rv32e_ex_stage
// PURPOSE
//  Execute-stage wrapper around the combinational RV32E ALU. Accepts decoded ops from ID over valid/ready,
//  holds them in the EX register that drives the ALU, captures result/flags plus branch resolution,
//  and queues them in an OUT_DEPTH-entry buffer toward MEM/WB. Supports flush on redirect.
// PARAMETERS
//  OUT_DEPTH       2  output buffer entries (2..4); 2 gives full throughput under 1-cycle backpressure
//  BR_ALIGN_CHECK  1  1: flag taken branch with target[1:0]!=0 as misaligned; 0: never flag
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  rst           in   1   synchronous, active-high reset
//  flush         in   1   kill EX register and output buffer this edge
//  in_valid      in   1   ID offers an op
//  in_ready      out  1   EX can accept this cycle
//  in_op         in   4   ALU op code (ADD=0 SLL=1 SLT=2 SLTU=3 XOR=4 SRL=5 OR=6 AND=7 SUB=8 SGEU=9 SEQ=10 SNE=11 SGE=12 SRA=13 SGT=14 SGTU=15)
//  in_a, in_b    in   32  operands
//  in_rd         in   4   destination register x0..x15
//  in_is_branch  in   1   conditional branch; in_op is the compare op
//  in_pc, in_imm in   32  branch PC and sign-extended offset
//  alu_op        out  4   to ALU op, registered EX value
//  alu_a, alu_b  out  32  to ALU operands, registered EX values
//  alu_result    in   32  from ALU
//  alu_zero, alu_neg, alu_ovf  in  1  ALU flags
//  out_valid     out  1   head of output buffer valid
//  out_ready     in   1   MEM/WB consumes head
//  out_result    out  32  ALU result (branch: 0)
//  out_rd        out  4   destination
//  out_we        out  1   1 iff !is_branch && rd!=0
//  out_flags     out  3   {ovf,neg,zero}
//  out_br_taken  out  1   branch taken (alu_result[0])
//  out_br_target out  32  in_pc+in_imm mod 2^32 (valid only when taken)
//  out_misalign  out  1   taken && BR_ALIGN_CHECK && target[1:0]!=0
// BEHAVIOUR
//  - Reset: EX valid=0, buffer count=0, rd/wr ptr=0; out_valid=0, in_ready=1, alu_op/a/b=0,
//    all out_* payload=0.
//  - EX register: loads on in_valid&&in_ready; alu_op/a/b driven only from it, never from in_*.
//  - ex_adv = ex_valid && (count<OUT_DEPTH || (out_valid&&out_ready)).
//  - in_ready = !ex_valid || ex_adv (combinational; no in_valid->in_ready path).
//  - On ex_adv, ALU outputs plus EX rd/is_branch/target are written into the buffer tail.
//  - Latency: accept at edge N -> ALU sees op cycle N+1 -> out_valid from cycle N+2.
//    Sustained 1 op/cycle when out_ready=1.
//  - Buffer: circular, pointers wrap at OUT_DEPTH; push and pop in same cycle leave count unchanged,
//    legal when full. No payload change while out_valid&&!out_ready.
//  - Branch: taken=alu_result[0]; target computed in EX, 32-bit wrap, no carry out; out_result=0, out_we=0.
//  - Flush: next edge ex_valid=0, count=0, ptrs=0; any in_valid same cycle is dropped (in_ready forced 0).
//    flush and rst together = rst.
//  - rst mid-operation: all in-flight ops discarded; no out_valid in cycle after reset.
//  - Illegal: none; all 16 op codes pass through. ovf meaningful only for ADD/SUB (ALU zeroes others).
// TESTING
//  1. ADD a=7 b=5 rd=3, out_ready=1 -> cycle N+2: out_result=12 we=1 rd=3 flags=000.
//  2. ADD a=0x7FFFFFFF b=1 rd=0 -> out_result=0x80000000, flags={1,1,0}, out_we=0.
//  3. Branch SLT a=-1 b=2, pc=0x100 imm=0xFFFFFFF0 -> taken=1, target=0xF0, misalign=0, we=0;
//     imm=2 -> target=0x102, misalign=1.
//  4. Stream 6 ADDs, out_ready=0 -> EX+OUT_DEPTH ops held, in_ready=0.
//     Raise out_ready -> all 6 in order, no loss/duplication.
//  5. 2 ops buffered, flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; dropped op never appears.
//  6. rst asserted while buffer full -> next cycle out_valid=0, in_ready=1, alu_op/a/b=0.

Source files
------------

// File: rtl/rv32e_ex_stage.sv
// RV32E execute stage: EX register feeding an external combinational ALU, plus an
// OUT_DEPTH-entry circular result buffer toward MEM/WB, with flush on redirect.
module rv32e_ex_stage #(
    parameter int OUT_DEPTH      = 2,
    parameter bit BR_ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [3:0]  in_rd,
    input  logic        in_is_branch,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_imm,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_rd,
    output logic        out_we,
    output logic [2:0]  out_flags,
    output logic        out_br_taken,
    output logic [31:0] out_br_target,
    output logic        out_misalign
);
    localparam int PW = (OUT_DEPTH > 2) ? 2 : 1;
    localparam int CW = (OUT_DEPTH > 3) ? 3 : 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(OUT_DEPTH - 1);

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  rd;
        logic        we;
        logic [2:0]  flags;
        logic        taken;
        logic [31:0] target;
        logic        misalign;
    } entry_t;

    logic          r_ex_valid;
    logic [3:0]    r_ex_op;
    logic [31:0]   r_ex_a;
    logic [31:0]   r_ex_b;
    logic [3:0]    r_ex_rd;
    logic          r_ex_is_br;
    logic [31:0]   r_ex_pc;
    logic [31:0]   r_ex_imm;

    entry_t        r_buf [OUT_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_out_valid;
    logic          w_pop;
    logic          w_ex_adv;
    logic          w_accept;
    logic [31:0]   w_target;
    logic          w_taken;
    entry_t        w_entry;
    entry_t        w_head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid && out_ready;
    // The EX op may leave when there is room, including the slot the head frees this cycle.
    assign w_ex_adv    = r_ex_valid && ((r_count < DEPTH_C) || w_pop);
    assign in_ready    = !flush && (!r_ex_valid || w_ex_adv);
    assign w_accept    = in_valid && in_ready;

    assign w_target = r_ex_pc + r_ex_imm;
    assign w_taken  = r_ex_is_br && alu_result[0];

    always_comb begin
        w_entry          = '0;
        w_entry.result   = r_ex_is_br ? 32'd0 : alu_result;
        w_entry.rd       = r_ex_rd;
        w_entry.we       = !r_ex_is_br && (r_ex_rd != 4'd0);
        w_entry.flags    = {alu_ovf, alu_neg, alu_zero};
        w_entry.taken    = w_taken;
        w_entry.target   = r_ex_is_br ? w_target : 32'd0;
        w_entry.misalign = w_taken && BR_ALIGN_CHECK && (w_target[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_rd    <= '0;
            r_ex_is_br <= 1'b0;
            r_ex_pc    <= '0;
            r_ex_imm   <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (flush) begin
            r_ex_valid <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_accept) begin
                r_ex_valid <= 1'b1;
                r_ex_op    <= in_op;
                r_ex_a     <= in_a;
                r_ex_b     <= in_b;
                r_ex_rd    <= in_rd;
                r_ex_is_br <= in_is_branch;
                r_ex_pc    <= in_pc;
                r_ex_imm   <= in_imm;
            end else if (w_ex_adv) begin
                r_ex_valid <= 1'b0;
            end
            if (w_ex_adv) begin
                r_buf[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_ex_adv && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_ex_adv && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign alu_op = r_ex_op;
    assign alu_a  = r_ex_a;
    assign alu_b  = r_ex_b;

    assign w_head        = r_buf[r_rd_ptr];
    assign out_valid     = w_out_valid;
    assign out_result    = w_head.result;
    assign out_rd        = w_head.rd;
    assign out_we        = w_head.we;
    assign out_flags     = w_head.flags;
    assign out_br_taken  = w_head.taken;
    assign out_br_target = w_head.target;
    assign out_misalign  = w_head.misalign;
endmodule
